// File: rtl/mul_pkg.sv
// -----------------------------------------------------------------------------
// mul_pkg
// Shared definitions for the sequential shift-add multiplier:
//   - state_e   : control FSM states (IDLE, RUN, FIX, DONE)
//   - MUL_W     : default operand width
//   - cnt_width : width of the RUN bit counter for a given operand width
// -----------------------------------------------------------------------------
package mul_pkg;

    localparam int MUL_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Counter runs W-1 down to 0, so $clog2(W) bits are always enough (W >= 2).
    function automatic int cnt_width(input int w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/mul_seq_if.sv
// -----------------------------------------------------------------------------
// mul_seq_if
// Operation request / product response bundle for mul_seq.
//   in_valid, in_ready, a, b, signed_mode : request handshake and operands
//   out_valid, out_ready, p               : product handshake and result
// Modports:
//   master : issuer/consumer side (drives operands and out_ready)
//   slave  : multiplier side (drives in_ready, out_valid, p)
// -----------------------------------------------------------------------------
interface mul_seq_if
    import mul_pkg::*;
#(
    parameter int W = MUL_W
) ();

    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           signed_mode;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] p;

    modport master (
        output in_valid, a, b, signed_mode, out_ready,
        input  in_ready, out_valid, p
    );

    modport slave (
        input  in_valid, a, b, signed_mode, out_ready,
        output in_ready, out_valid, p
    );

endinterface

// File: rtl/add_w.sv
// -----------------------------------------------------------------------------
// add_w
// Parametrised W-bit adder with carry-in and carry-out.
//   a_i, b_i : W-bit addends
//   ci_i     : carry-in
//   s_o      : W-bit sum
//   co_o     : carry-out
// -----------------------------------------------------------------------------
module add_w
    import mul_pkg::*;
#(
    parameter int W = MUL_W
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         ci_i,
    output logic [W-1:0] s_o,
    output logic         co_o
);

    assign {co_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, ci_i};

endmodule

// File: rtl/mul_seq.sv
// -----------------------------------------------------------------------------
// mul_seq
// Radix-2 sequential shift-add multiplier, W x W -> 2W, unsigned or signed.
// Signed operands are reduced to magnitudes on accept, the magnitudes are
// multiplied in W RUN cycles, and FIX negates the product when the operand
// signs differ.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (aborts any operation)
//   bus  : mul_seq_if.slave (request/response handshake, operands, product)
// Latency: accept edge = 0, out_valid first high in cycle W+2.
// -----------------------------------------------------------------------------
module mul_seq
    import mul_pkg::*;
#(
    parameter int W = MUL_W
) (
    input  logic     clk,
    input  logic     rst,
    mul_seq_if.slave bus
);

    localparam int CW = cnt_width(W);

    state_e         state_q, state_d;
    logic [W-1:0]   mcand_q, mcand_d;     // multiplicand magnitude
    logic [W-1:0]   mplier_q, mplier_d;   // multiplier bits / low product half
    logic [W-1:0]   acc_hi_q, acc_hi_d;   // upper product half
    logic           neg_q, neg_d;         // product needs negation in FIX
    logic [CW-1:0]  cnt_q, cnt_d;

    logic           accept_s;
    logic [W-1:0]   a_mag_s, b_mag_s;
    logic [W-1:0]   addend_s;
    logic [W-1:0]   run_sum_s;
    logic           run_co_s;
    logic [2*W-1:0] fix_sum_s;
    logic           fix_co_unused_s;

    assign accept_s = (state_q == ST_IDLE) && bus.in_valid;

    // In W bits, |-2^(W-1)| wraps back to 2^(W-1), which is the correct
    // unsigned magnitude, so no extra bit is needed.
    assign a_mag_s = (bus.signed_mode && bus.a[W-1]) ? (~bus.a + W'(1)) : bus.a;
    assign b_mag_s = (bus.signed_mode && bus.b[W-1]) ? (~bus.b + W'(1)) : bus.b;

    assign addend_s = mplier_q[0] ? mcand_q : '0;

    // RUN accumulate step: acc_hi + (multiplier LSB ? multiplicand : 0).
    add_w #(.W(W)) u_add_run (
        .a_i  (acc_hi_q),
        .b_i  (addend_s),
        .ci_i (1'b0),
        .s_o  (run_sum_s),
        .co_o (run_co_s)
    );

    // FIX negation gets its own 2W-bit instance (~acc + 1) so FIX stays a
    // single cycle and the RUN adder keeps a plain W-bit operand path.
    add_w #(.W(2*W)) u_add_fix (
        .a_i  (~{acc_hi_q, mplier_q}),
        .b_i  ('0),
        .ci_i (1'b1),
        .s_o  (fix_sum_s),
        .co_o (fix_co_unused_s)
    );

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) state_d = ST_RUN;
                else          state_d = ST_IDLE;
            end
            ST_RUN: begin
                if (cnt_q == '0) state_d = ST_FIX;
                else             state_d = ST_RUN;
            end
            ST_FIX:  state_d = ST_DONE;
            ST_DONE: begin
                if (bus.out_ready) state_d = ST_IDLE;
                else               state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from registered state; rst only forces handshakes low.
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.p         = {acc_hi_q, mplier_q};
        case (state_q)
            ST_IDLE: bus.in_ready  = !rst;
            ST_DONE: bus.out_valid = !rst;
            default: begin
                bus.in_ready  = 1'b0;
                bus.out_valid = 1'b0;
            end
        endcase
    end

    // Datapath next-state: capture, shift-add, optional negate.
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_hi_d = acc_hi_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    mcand_d  = a_mag_s;
                    mplier_d = b_mag_s;
                    acc_hi_d = '0;
                    neg_d    = bus.signed_mode & (bus.a[W-1] ^ bus.b[W-1]);
                    cnt_d    = CW'(W-1);
                end else begin
                    cnt_d    = cnt_q;
                end
            end
            ST_RUN: begin
                // Shift {carry, sum, multiplier} right by one.
                acc_hi_d = {run_co_s, run_sum_s[W-1:1]};
                mplier_d = {run_sum_s[0], mplier_q[W-1:1]};
                cnt_d    = cnt_q - CW'(1);
            end
            ST_FIX: begin
                if (neg_q) begin
                    {acc_hi_d, mplier_d} = fix_sum_s;
                end else begin
                    acc_hi_d = acc_hi_q;
                end
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    // Datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_hi_q <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_hi_q <= acc_hi_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mul_seq.sv
// -----------------------------------------------------------------------------
// tb_mul_seq
// Directed W=16 checks (latency, signed/unsigned corner products,
// backpressure, reset mid-RUN) and 1000 random W=8 operations compared with
// an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_mul_seq;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    mul_seq_if #(.W(16)) if16 ();
    mul_seq_if #(.W(8))  if8 ();

    mul_seq #(.W(16)) dut16 (.clk(clk), .rst(rst), .bus(if16));
    mul_seq #(.W(8))  dut8  (.clk(clk), .rst(rst), .bus(if8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: true integer product of the operands, truncated to 2w bits.
    function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b,
                                          input bit sm, input int w);
        longint sa;
        longint sb;
        logic [63:0] prod;
        logic [63:0] mask;
        sa = longint'(a);
        sb = longint'(b);
        if (sm && a[w-1]) sa = sa - (longint'(1) << w);
        if (sm && b[w-1]) sb = sb - (longint'(1) << w);
        prod = 64'(sa * sb);
        mask = (64'd1 << (2 * w)) - 64'd1;
        return prod & mask;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One W=16 operation; hold > 0 keeps out_ready low for hold cycles.
    task automatic op16(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input bit sm, input logic [31:0] exp, input int hold);
        int lat;
        @(negedge clk);
        chk({tag, "_rdy"}, 64'(if16.in_ready), 64'd1);
        if16.a           = a;
        if16.b           = b;
        if16.signed_mode = sm;
        if16.in_valid    = 1'b1;
        if16.out_ready   = (hold == 0);
        @(posedge clk);
        #1;
        if16.in_valid    = 1'b0;
        if16.a           = 16'($urandom);
        if16.b           = 16'($urandom);
        if16.signed_mode = ~sm;
        lat = 0;
        @(negedge clk);
        while (!if16.out_valid && lat < 64) begin
            lat++;
            @(negedge clk);
        end
        chk({tag, "_lat"}, 64'(lat), 64'd17);
        chk({tag, "_p"}, 64'(if16.p), 64'(exp));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_p"}, 64'(if16.p), 64'(exp));
            chk({tag, "_hold_ov"}, 64'(if16.out_valid), 64'd1);
            chk({tag, "_hold_ir"}, 64'(if16.in_ready), 64'd0);
        end
        if16.out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_ir_back"}, 64'(if16.in_ready), 64'd1);
        chk({tag, "_ov_drop"}, 64'(if16.out_valid), 64'd0);
    endtask

    initial begin
        logic [7:0]  ra;
        logic [7:0]  rb;
        bit          rs;
        logic [63:0] exp8;
        int          lat;
        bit          seen;

        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        if16.in_valid = 1'b0; if16.a = 16'd0; if16.b = 16'd0;
        if16.signed_mode = 1'b0; if16.out_ready = 1'b1;
        if8.in_valid = 1'b0; if8.a = 8'd0; if8.b = 8'd0;
        if8.signed_mode = 1'b0; if8.out_ready = 1'b1;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(if16.in_ready), 64'd0);
        chk("rst_out_valid", 64'(if16.out_valid), 64'd0);
        chk("rst_p", 64'(if16.p), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rel_in_ready", 64'(if16.in_ready), 64'd1);
        chk("rel_in_ready8", 64'(if8.in_ready), 64'd1);

        // Directed W=16 operations.
        op16("u50x50",   16'd50,    16'd50,    1'b0, 32'h0000_09C4, 0);
        op16("uffxff",   16'hFFFF,  16'hFFFF,  1'b0, 32'hFFFE_0001, 0);
        op16("u0x1234",  16'h0000,  16'h1234,  1'b0, 32'h0000_0000, 0);
        op16("sm3x5",    16'hFFFD,  16'h0005,  1'b1, 32'hFFFF_FFF1, 0);
        op16("smin2",    16'h8000,  16'h8000,  1'b1, 32'h4000_0000, 0);
        op16("sminx1",   16'h8000,  16'h0001,  1'b1, 32'hFFFF_8000, 0);
        op16("bp",       16'h00FF,  16'h0101,  1'b0, 32'h0000_FFFF, 5);

        // Reset in cycle 7 of a running operation.
        @(negedge clk);
        chk("rr_rdy", 64'(if16.in_ready), 64'd1);
        if16.a = 16'h1234; if16.b = 16'h5678; if16.signed_mode = 1'b0;
        if16.in_valid = 1'b1;
        @(posedge clk);
        #1 if16.in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rr_in_ready_hi", 64'(if16.in_ready), 64'd0);
        chk("rr_out_valid_hi", 64'(if16.out_valid), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rr_in_ready_after", 64'(if16.in_ready), 64'd1);
        chk("rr_p_cleared", 64'(if16.p), 64'd0);
        seen = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (if16.out_valid) seen = 1'b1;
        end
        chk("rr_no_out_valid", 64'(seen), 64'd0);
        op16("rr3x4", 16'd3, 16'd4, 1'b0, 32'd12, 0);

        // Random W=8 operations with in_valid toggling while busy.
        for (int i = 0; i < 1000; i++) begin
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rs   = 1'($urandom_range(0, 1));
            exp8 = model(64'(ra), 64'(rb), rs, 8);
            @(negedge clk);
            chk("r8_rdy", 64'(if8.in_ready), 64'd1);
            if8.a = ra; if8.b = rb; if8.signed_mode = rs; if8.in_valid = 1'b1;
            @(posedge clk);
            #1 if8.in_valid = 1'b0;
            lat = 0;
            @(negedge clk);
            while (!if8.out_valid && lat < 64) begin
                if8.in_valid    = 1'($urandom_range(0, 1));
                if8.a           = 8'($urandom);
                if8.b           = 8'($urandom);
                if8.signed_mode = 1'($urandom_range(0, 1));
                lat++;
                @(negedge clk);
            end
            if8.in_valid = 1'b0;
            chk("r8_lat", 64'(lat), 64'd9);
            chk("r8_p", 64'(if8.p), exp8);
        end
        @(negedge clk);
        chk("r8_final_rdy", 64'(if8.in_ready), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
